// File: rtl/bounce_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// bounce_scanner
//
// Free-running one-hot "bounce" pattern source for LED rows and display scan.
// A single lit position dwells at home (position 0), sweeps up to WIDTH-1 and
// then either walks back down (bounce) or jumps straight home (rotate).
//
// Parameters
//   WIDTH  number of output bits / scan positions (>= 2)
//   DWELL  step periods spent at position 0 per visit, arrival step included (>= 1)
//   DIV    clock cycles per step (>= 1)
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high; wins over enable and mode
//   enable  in   1 = prescaler and scanner run, 0 = all state frozen
//   mode    in   0 = bounce, 1 = rotate; sampled on step cycles only
//   count   out  [WIDTH]          one-hot scan pattern (plus tail, see below)
//   pos     out  [$clog2(WIDTH)]  current position index
//   dir     out  1 = moving up, 0 = moving down
//   wrap    out  one-cycle pulse when the pattern arrives back at position 0
//
// Build option
//   BOUNCE_SCANNER_TAIL_EN  when defined, count also shows the previous
//   position for one step period after every move (a short comet tail).
//   Left undefined, count is strictly one-hot and no tail register exists.
// -----------------------------------------------------------------------------
module bounce_scanner #(
   parameter int WIDTH = 8,
   parameter int DWELL = 5,
   parameter int DIV   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     mode,
   output logic [WIDTH-1:0]         count,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic                     dir,
   output logic                     wrap
);

   localparam int PW  = $clog2(WIDTH);
   localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int PCW = (DIV > 1)   ? $clog2(DIV)   : 1;

   localparam logic [PW-1:0]  POS_MAX  = PW'(WIDTH - 1);
   localparam logic [PW-1:0]  POS_TURN = PW'(WIDTH - 2);
   localparam logic [DW-1:0]  DCNT_MAX = DW'(DWELL - 1);
   localparam logic [PCW-1:0] PCNT_MAX = PCW'(DIV - 1);

   logic [DW-1:0]  dcnt;
   logic [PCW-1:0] pcnt;

   logic           step;
   logic           arrive;
   logic           moved;
   logic [PW-1:0]  nxt_pos;
   logic           nxt_dir;
   logic [DW-1:0]  nxt_dcnt;

   function automatic logic [WIDTH-1:0] onehot(input logic [PW-1:0] p);
      return WIDTH'(1) << p;
   endfunction

   assign step  = enable && (pcnt == PCNT_MAX);
   assign moved = (nxt_pos != pos);

   // Next position/direction/dwell for a step, evaluated every cycle and
   // only committed when step is true.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch can be inferred.
      nxt_pos  = pos;
      nxt_dir  = dir;
      nxt_dcnt = dcnt;
      arrive   = 1'b0;

      if (pos == '0) begin
         if (dcnt != DCNT_MAX) begin
            nxt_dcnt = dcnt + 1'b1;
         end else begin
            nxt_pos  = PW'(1);
            nxt_dir  = 1'b1;
            nxt_dcnt = '0;
         end
      end else if (dir) begin
         if (pos != POS_MAX) begin
            nxt_pos = pos + 1'b1;
         end else if (!mode && (WIDTH > 2)) begin
            nxt_pos = POS_TURN;
            nxt_dir = 1'b0;
         end else begin
            // Rotate, or a two-position bounce whose turn point is home.
            arrive = 1'b1;
         end
      end else if (!mode) begin
         if (pos == PW'(1)) arrive = 1'b1;
         else               nxt_pos = pos - 1'b1;
      end else begin
         // Switched to rotate while descending: turn round and climb.
         nxt_dir = 1'b1;
         nxt_pos = pos + 1'b1;
      end

      if (arrive) begin
         nxt_pos  = '0;
         nxt_dir  = 1'b1;
         nxt_dcnt = '0;
      end
   end

`ifdef BOUNCE_SCANNER_TAIL_EN
   logic [WIDTH-1:0] tail;
   logic [WIDTH-1:0] nxt_tail;

   // The lit head bit is the pattern minus its tail; it becomes the new tail
   // when the head moves, and the tail is dropped on a dwell step.
   assign nxt_tail = moved ? (count & ~tail) : '0;
`endif

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos   <= '0;
         dir   <= 1'b1;
         dcnt  <= '0;
         pcnt  <= '0;
         count <= WIDTH'(1);
         wrap  <= 1'b0;
`ifdef BOUNCE_SCANNER_TAIL_EN
         tail  <= '0;
`endif
      end else begin
         wrap <= 1'b0;
         if (enable) begin
            pcnt <= step ? '0 : pcnt + 1'b1;
            if (step) begin
               pos  <= nxt_pos;
               dir  <= nxt_dir;
               dcnt <= nxt_dcnt;
               wrap <= arrive;
`ifdef BOUNCE_SCANNER_TAIL_EN
               tail  <= nxt_tail;
               count <= onehot(nxt_pos) | nxt_tail;
`else
               count <= onehot(nxt_pos);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_bounce_scanner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_bounce_scanner
//
// Self-checking bench for bounce_scanner. Three instances share one clock:
// defaults (8/5/1), a DIV=3 prescaled copy and a WIDTH=2/DWELL=1 copy.
// Expected values come from a position model of the sweep; the tail bits are
// included when BOUNCE_SCANNER_TAIL_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_bounce_scanner;

`ifdef BOUNCE_SCANNER_TAIL_EN
   localparam bit TAIL = 1'b1;
`else
   localparam bit TAIL = 1'b0;
`endif

   typedef struct {
      logic       enable;
      logic       mode;
      logic [7:0] count;
      logic [2:0] pos;
      logic       dir;
      logic       wrap;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic       r_def = 1'b1, en_def = 1'b0, md_def = 1'b0;
   logic [7:0] cnt_def;
   logic [2:0] pos_def;
   logic       dir_def, wrap_def;
   // DIV=3 instance
   logic       r_div = 1'b1, en_div = 1'b0, md_div = 1'b0;
   logic [7:0] cnt_div;
   logic [2:0] pos_div;
   logic       dir_div, wrap_div;
   // WIDTH=2, DWELL=1 instance
   logic       r_w2 = 1'b1, en_w2 = 1'b0, md_w2 = 1'b0;
   logic [1:0] cnt_w2;
   logic [0:0] pos_w2;
   logic       dir_w2, wrap_w2;

   bounce_scanner #(.WIDTH(8), .DWELL(5), .DIV(1)) u_def (
      .clk(clk), .reset(r_def), .enable(en_def), .mode(md_def),
      .count(cnt_def), .pos(pos_def), .dir(dir_def), .wrap(wrap_def));

   bounce_scanner #(.WIDTH(8), .DWELL(5), .DIV(3)) u_div (
      .clk(clk), .reset(r_div), .enable(en_div), .mode(md_div),
      .count(cnt_div), .pos(pos_div), .dir(dir_div), .wrap(wrap_div));

   bounce_scanner #(.WIDTH(2), .DWELL(1), .DIV(1)) u_w2 (
      .clk(clk), .reset(r_w2), .enable(en_w2), .mode(md_w2),
      .count(cnt_w2), .pos(pos_w2), .dir(dir_w2), .wrap(wrap_w2));

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t sb[$];

   // ---- reference model of the 8/5 sweep, indexed by step number k --------
   function automatic int pos_at(int k, bit rot);
      int m;
      if (rot) begin
         m = k % 12;
         return (m < 5) ? 0 : m - 4;
      end
      m = k % 18;
      if (m < 5)  return 0;
      if (m < 12) return m - 4;
      return 18 - m;
   endfunction

   function automatic bit dir_at(int k, bit rot);
      if (rot) return 1'b1;
      return ((k % 18) < 12);
   endfunction

   function automatic bit wrap_at(int k, bit rot);
      return (k > 0) && ((k % (rot ? 12 : 18)) == 0);
   endfunction

   function automatic logic [7:0] count_at(int k, bit rot);
      logic [7:0] c;
      c = 8'd1 << pos_at(k, rot);
      if (TAIL && k > 0 && pos_at(k - 1, rot) != pos_at(k, rot))
         c = c | (8'd1 << pos_at(k - 1, rot));
      return c;
   endfunction

   function automatic vec_t mk(logic en, logic md, logic [7:0] c, int p, logic d, logic w);
      vec_t v;
      v.enable = en;
      v.mode   = md;
      v.count  = c;
      v.pos    = 3'(p);
      v.dir    = d;
      v.wrap   = w;
      return v;
   endfunction

   function automatic vec_t model_vec(int k, bit rot);
      return mk(1'b1, rot, count_at(k, rot), pos_at(k, rot), dir_at(k, rot), wrap_at(k, rot));
   endfunction

   // ---- checking ----------------------------------------------------------
   task automatic check(input string name, input int tag, input string field,
                        input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] %s: got %0h want %0h", name, tag, field, act, exp);
      end
   endtask

   // Drive one cycle's inputs, queue the expected outputs for that cycle,
   // compare on the falling edge, then move just past the next rising edge.
   task automatic run_cycle(input int inst, input string name, input int tag, input vec_t v);
      vec_t e;
      case (inst)
         0:       begin en_def = v.enable; md_def = v.mode; end
         1:       begin en_div = v.enable; md_div = v.mode; end
         default: begin en_w2  = v.enable; md_w2  = v.mode; end
      endcase
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      case (inst)
         0: begin
            check(name, tag, "count", {24'd0, cnt_def}, {24'd0, e.count});
            check(name, tag, "pos",   {29'd0, pos_def}, {29'd0, e.pos});
            check(name, tag, "dir",   {31'd0, dir_def}, {31'd0, e.dir});
            check(name, tag, "wrap",  {31'd0, wrap_def}, {31'd0, e.wrap});
         end
         1: begin
            check(name, tag, "count", {24'd0, cnt_div}, {24'd0, e.count});
            check(name, tag, "pos",   {29'd0, pos_div}, {29'd0, e.pos});
            check(name, tag, "dir",   {31'd0, dir_div}, {31'd0, e.dir});
            check(name, tag, "wrap",  {31'd0, wrap_div}, {31'd0, e.wrap});
         end
         default: begin
            check(name, tag, "count", {30'd0, cnt_w2}, {24'd0, e.count});
            check(name, tag, "pos",   {31'd0, pos_w2}, {29'd0, e.pos});
            check(name, tag, "dir",   {31'd0, dir_w2}, {31'd0, e.dir});
            check(name, tag, "wrap",  {31'd0, wrap_w2}, {31'd0, e.wrap});
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   // Reset one instance; returns inside post-reset cycle 0.
   task automatic do_reset(input int inst);
      @(negedge clk);
      case (inst)
         0:       r_def = 1'b1;
         1:       r_div = 1'b1;
         default: r_w2  = 1'b1;
      endcase
      @(posedge clk);
      #1;
      case (inst)
         0:       r_def = 1'b0;
         1:       r_div = 1'b0;
         default: r_w2  = 1'b0;
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[66];
      vec_t v;
      int   lc;
      bit   last_en;
      bit   en;

      // 0..39: bounce from reset; 40..65: rotate from reset
      for (int i = 0; i < 40; i++) tbl[i]      = model_vec(i, 1'b0);
      for (int i = 0; i < 26; i++) tbl[40 + i] = model_vec(i, 1'b1);

      repeat (2) @(posedge clk);
      #1;

      // bounce: 01 x5, up to 80, back down, wrap at 18 and 36
      do_reset(0);
      for (int i = 0; i < 40; i++) run_cycle(0, "bounce", i, tbl[i]);

      // rotate: 80 followed by 01, wrap at 12 and 24
      do_reset(0);
      for (int i = 40; i < 66; i++) run_cycle(0, "rotate", i - 40, tbl[i]);

      // reset while descending at pos 5: home next cycle with a full dwell
      do_reset(0);
      for (int i = 0; i < 13; i++) run_cycle(0, "rst_pre", i, tbl[i]);
      r_def = 1'b1;
      run_cycle(0, "rst_at5", 13, tbl[13]);
      r_def = 1'b0;
      for (int i = 0; i < 7; i++) run_cycle(0, "rst_post", i, tbl[i]);

      // bounce -> rotate at pos 4 descending: 5,6,7 upward then home
      do_reset(0);
      for (int i = 0; i < 14; i++) run_cycle(0, "sw_pre", i, tbl[i]);
      v = tbl[14];
      v.mode = 1'b1;
      run_cycle(0, "sw_at4", 14, v);
      run_cycle(0, "sw", 15, mk(1'b1, 1'b1, TAIL ? 8'h30 : 8'h20, 5, 1'b1, 1'b0));
      run_cycle(0, "sw", 16, mk(1'b1, 1'b1, TAIL ? 8'h60 : 8'h40, 6, 1'b1, 1'b0));
      run_cycle(0, "sw", 17, mk(1'b1, 1'b1, TAIL ? 8'hC0 : 8'h80, 7, 1'b1, 1'b0));
      run_cycle(0, "sw", 18, mk(1'b1, 1'b1, TAIL ? 8'h81 : 8'h01, 0, 1'b1, 1'b1));
      run_cycle(0, "sw", 19, mk(1'b1, 1'b1, 8'h01, 0, 1'b1, 1'b0));
      en_def = 1'b0;

      // DIV=3 with a 10-cycle freeze while at pos 3; lc counts enabled edges
      do_reset(1);
      lc      = 0;
      last_en = 1'b1;
      for (int c = 0; c < 70; c++) begin
         en = !(c >= 22 && c < 32);
         v  = mk(en, 1'b0, count_at(lc / 3, 1'b0), pos_at(lc / 3, 1'b0),
                 dir_at(lc / 3, 1'b0),
                 wrap_at(lc / 3, 1'b0) && last_en && (lc % 3 == 0));
         run_cycle(1, "div3", c, v);
         if (en) lc++;
         last_en = en;
      end
      en_div = 1'b0;

      // WIDTH=2, DWELL=1: 01,02 alternating, wrap on every return to 0
      do_reset(2);
      for (int c = 0; c < 8; c++) begin
         v = mk(1'b1, 1'b0,
                TAIL ? ((c == 0) ? 8'h01 : 8'h03) : ((c % 2 == 1) ? 8'h02 : 8'h01),
                c % 2, 1'b1, (c > 0) && (c % 2 == 0));
         run_cycle(2, "w2", c, v);
      end
      en_w2 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bounce_scanner.md
# bounce_scanner

Parametrised one-hot "bounce" scanner for LED and display-scan use. It generalises the fixed 8-bit, 18-state shift counter to configurable width, home-position dwell and step rate. It adds an enable, a selectable rotate mode, position and direction status, and a sweep-complete pulse. It is a free-running pattern source clocked by the system clock and driven by panel or display logic.

## Interface
Parameters:
- WIDTH, 8, number of output bits / scan positions; legal range ≥2.
- DWELL, 5, step periods spent at position 0 per visit, including the arrival step; legal range ≥1.
- DIV, 1, clock cycles per step (prescaler); legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  1 = prescaler and scanner run; 0 = all state frozen.
- mode  in  1  0 = bounce (up then down); 1 = rotate (up, then jump to 0).
- count  out  WIDTH  one-hot scan pattern, bit pos set (see Configuration).
- pos  out  $clog2(WIDTH)  current position index.
- dir  out  1  1 = moving up, 0 = moving down.
- wrap  out  1  one-cycle pulse on arrival at position 0 after a sweep.

## Operation
- Internal registers:
  - pos.
  - dir.
  - dwell counter dcnt, range 0..DWELL-1.
  - prescaler pcnt, range 0..DIV-1.
- All outputs are registered.
- pcnt advances only while enable=1. It wraps at DIV-1.
- A "step" happens in a cycle where enable=1 and pcnt==DIV-1. With DIV=1, every enabled cycle is a step.
- On each step, the following rules apply in priority order:
  - pos==0 and dcnt<DWELL-1: dcnt++, pos stays 0.
  - pos==0 and dcnt==DWELL-1: pos←1, dir←1, dcnt←0.
  - dir==1 and pos<WIDTH-1: pos++.
  - dir==1 and pos==WIDTH-1, mode=0: pos←WIDTH-2, dir←0. When WIDTH=2, this is pos←0 (arrival).
  - dir==1 and pos==WIDTH-1, mode=1: pos←0 (arrival).
  - dir==0 and mode=0: pos--. Reaching 0 is an arrival.
  - dir==0 and mode=1 (mode changed mid-descent): dir←1, pos++.
- Arrival at position 0: dcnt←0, dir←1, and wrap=1 in the cycle count first shows position 0.
- Sweep period in steps:
  - Bounce: DWELL+2·WIDTH−3. Defaults give 18, identical to the legacy sequence.
  - Rotate: DWELL+WIDTH−1.
- mode is sampled on each step only. A change takes effect on the next step.
- enable=0 holds pos, dir, dcnt, pcnt and count. wrap is 0 while frozen.

## Timing
- Reset values:
  - count = 1 (bit 0 only).
  - pos = 0, dir = 1, dcnt = 0, pcnt = 0.
  - wrap = 0.
  - tail register = 0.
- Reset has priority over enable and mode. Mid-operation reset returns to the home state on the next edge and restarts a full DWELL dwell.
- Latency: the outputs reflect a step in the cycle after the edge on which the step condition was true.
- wrap is high for exactly one clk cycle per arrival, independent of DIV. It is not asserted after reset.
- Each position is held DIV cycles while enabled. Position 0 is held DWELL·DIV cycles.

## Configuration
- BOUNCE_SCANNER_TAIL_EN defined:
  - count = onehot(pos) | tail. tail holds the previous onehot(pos) for the step period immediately after a position change.
  - tail clears on any step that does not change pos (dwell) and on reset.
  - WIDTH=2 behaves identically.
- Undefined: count is strictly onehot(pos), and the tail register is not built.

## Test plan
- Defaults, enable=1, mode=0, 40 cycles after reset (post-reset cycle 0):
  - count is 01 for cycles 0–4.
  - Then 02,04,08,10,20,40,80 for cycles 5–11.
  - Then 40,20,10,08,04,02 for cycles 12–17.
  - Then 01 at cycle 18.
  - wrap=1 only at cycles 18 and 36.
- mode=1, defaults: after 80 comes 01. Period is 12 cycles. wrap at cycles 12 and 24. dir stays 1.
- DIV=3: every value is held 3 cycles and 01 is held 15. Deassert enable for 10 cycles at pos=3: count, pos and pcnt are unchanged, and the sequence resumes exactly where it stopped.
- Reset asserted at pos=5, dir=0: the next cycle shows count=01, pos=0, dir=1, wrap=0, followed by a full 5-cycle dwell.
- Bounce→rotate switch at pos=4 with dir=0: the next step gives pos=5, dir=1. Then 6, 7, 0, with wrap pulsing on 0. WIDTH=2, DWELL=1, mode=0: count alternates 01,02 every cycle.
- With BOUNCE_SCANNER_TAIL_EN, defaults:
  - cycle 5 shows 03, cycle 6 shows 06.
  - cycle 12 shows C0.
  - cycle 18 shows 03, cycle 19 shows 01.
